// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// PC select encoding matches the decoder's next-PC select field.
package instr_fetch_unit_pkg;
  localparam int          WORD    = 32;
  localparam logic [31:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    PC_SEL_REG    = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_JUMP   = 2'b10,
    PC_SEL_SEQ    = 2'b11
  } pc_sel_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: imem request/response channels plus the decoder handshake.
// master = fetch unit, slave = the memory/decoder environment.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic            imem_req_valid;
  logic [WORD-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [WORD-1:0] imem_rsp_data;
  logic            instr_valid;
  logic [WORD-1:0] instr;
  logic [WORD-1:0] instr_pc;
  logic            instr_ready;
  logic [1:0]      pc_mux_sel;
  logic            branch_taken;
  logic [WORD-1:0] reg_target;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_ready, pc_mux_sel, branch_taken, reg_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_ready, pc_mux_sel, branch_taken, reg_target
  );
endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC resolution for the instruction being accepted.
// Sequential flow and not-taken branches report no redirect.
module next_pc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [WORD-1:0] i_instr,
  input  logic [WORD-1:0] i_instr_pc,
  input  logic [1:0]      i_pc_mux_sel,
  input  logic            i_branch_taken,
  input  logic [WORD-1:0] i_reg_target,
  output logic            o_redirect,
  output logic [WORD-1:0] o_target
);
  logic [WORD-1:0] w_pc4;
  logic [WORD-1:0] w_br_off;
  logic            w_unused;

  assign w_pc4    = i_instr_pc + PC_INCR;
  assign w_br_off = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
  assign w_unused = ^{i_instr[31:26], i_reg_target[1:0]};

  always_comb begin
    o_redirect = 1'b0;
    o_target   = w_pc4;
    case (pc_sel_e'(i_pc_mux_sel))
      PC_SEL_REG: begin
        o_redirect = 1'b1;
        o_target   = {i_reg_target[31:2], 2'b00};
      end
      PC_SEL_BRANCH: begin
        o_redirect = i_branch_taken;
        o_target   = w_pc4 + w_br_off;
      end
      PC_SEL_JUMP: begin
        o_redirect = 1'b1;
        o_target   = {w_pc4[31:28], i_instr[25:0], 2'b00};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single outstanding imem request, output register plus
// one-entry skid toward the decoder, redirect with wrong-path squashing.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);
  logic            r_run, r_outstanding, r_drop, r_skid_valid, r_out_valid;
  logic [WORD-1:0] r_fetch_pc, r_req_pc;
  logic [WORD-1:0] r_skid_instr, r_skid_pc, r_out_instr, r_out_pc;

  logic            w_accept, w_redirect, w_redir;
  logic            w_req_valid, w_req_hs, w_rsp, w_rsp_keep;
  logic [WORD-1:0] w_target;

  next_pc_calc u_next_pc (
    .i_instr        (r_out_instr),
    .i_instr_pc     (r_out_pc),
    .i_pc_mux_sel   (bus.pc_mux_sel),
    .i_branch_taken (bus.branch_taken),
    .i_reg_target   (bus.reg_target),
    .o_redirect     (w_redirect),
    .o_target       (w_target)
  );

  // r_run holds requests off for the cycle in which reset is released
  assign w_req_valid = r_run & ~r_outstanding & ~r_skid_valid;
  assign w_req_hs    = w_req_valid & bus.imem_req_ready;
  assign w_rsp       = bus.imem_rsp_valid & r_outstanding;
  assign w_accept    = r_out_valid & bus.instr_ready;
  assign w_redir     = w_accept & w_redirect;
  assign w_rsp_keep  = w_rsp & ~r_drop & ~w_redir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run         <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_instr  <= '0;
      r_skid_pc     <= '0;
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_pc      <= '0;
    end else begin
      r_run <= 1'b1;

      if (w_redir)       r_fetch_pc <= w_target;
      else if (w_req_hs) r_fetch_pc <= r_fetch_pc + PC_INCR;

      if (w_req_hs) r_req_pc <= r_fetch_pc;

      if (w_req_hs)   r_outstanding <= 1'b1;
      else if (w_rsp) r_outstanding <= 1'b0;

      // Anything in flight at a redirect belongs to the wrong path
      if (w_redir)              r_drop <= w_req_hs | (r_outstanding & ~w_rsp);
      else if (w_rsp && r_drop) r_drop <= 1'b0;

      if (w_redir) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        if (r_skid_valid) begin
          r_out_instr <= r_skid_instr;
          r_out_pc    <= r_skid_pc;
        end else if (w_rsp_keep) begin
          r_out_instr <= bus.imem_rsp_data;
          r_out_pc    <= r_req_pc;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (!r_out_valid && w_rsp_keep) begin
        r_out_valid <= 1'b1;
        r_out_instr <= bus.imem_rsp_data;
        r_out_pc    <= r_req_pc;
      end

      // No request is issued while the skid is full, so fill and drain never coincide
      if (w_redir || w_accept) begin
        r_skid_valid <= 1'b0;
      end else if (w_rsp_keep && r_out_valid) begin
        r_skid_valid <= 1'b1;
        r_skid_instr <= bus.imem_rsp_data;
        r_skid_pc    <= r_req_pc;
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.instr_valid    = r_out_valid;
  assign bus.instr          = r_out_instr;
  assign bus.instr_pc       = r_out_pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: 1-cycle imem model with addr-tagged words,
// backpressure, branch/jump/jr redirects, squash cases and reset mid-request.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   vec  = 0;
  int   miss = 0;

  logic        mem_v = 1'b0, inj_v = 1'b0;
  logic [31:0] mem_d = '0, inj_d = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_a = '0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.imem_rsp_valid = mem_v | inj_v;
  assign bus.imem_rsp_data  = inj_v ? inj_d : mem_d;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h1000_FFFE;
      32'h0000_0100: return 32'h0800_0040;
      default:       return 32'hE000_0000 | a;
    endcase
  endfunction

  // Memory: a handshake seen before an edge is answered during the following cycle
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        mem_v = 1'b0;
        pend  = 1'b0;
      end else begin
        mem_v  = pend;
        mem_d  = mem_word(pend_a);
        pend   = bus.imem_req_valid & bus.imem_req_ready;
        pend_a = bus.imem_req_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("instr_valid_timeout", {31'd0, bus.instr_valid}, 32'd1);
  endtask

  // Wait for an instruction, optionally stall dly cycles, check it, then accept it
  task automatic take(input logic [31:0] epc, input logic [31:0] ein, input logic [1:0] sel,
                      input logic bt, input logic [31:0] rt, input int dly);
    wait_valid();
    repeat (dly) @(negedge clk);
    chk("instr_pc", bus.instr_pc, epc);
    chk("instr", bus.instr, ein);
    bus.instr_ready  = 1'b1;
    bus.pc_mux_sel   = sel;
    bus.branch_taken = bt;
    bus.reg_target   = rt;
    @(negedge clk);
    bus.instr_ready  = 1'b0;
    bus.pc_mux_sel   = 2'b11;
    bus.branch_taken = 1'b0;
    bus.reg_target   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.instr_ready  = 1'b0;
    bus.pc_mux_sel   = 2'b11;
    bus.branch_taken = 1'b0;
    bus.reg_target   = '0;
    bus.imem_req_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);

    // First request the cycle after release, held while memory is not ready
    bus.imem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0);
    @(negedge clk);
    chk("held_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("held_req_addr", bus.imem_req_addr, 32'h0);
    bus.imem_req_ready = 1'b1;

    take(32'h0, 32'hE000_0000, 2'b11, 1'b0, 32'h0, 0);
    take(32'h4, 32'hE000_0004, 2'b11, 1'b0, 32'h0, 0);
    take(32'h8, 32'hE000_0008, 2'b11, 1'b0, 32'h0, 0);
    take(32'hC, 32'hE000_000C, 2'b11, 1'b0, 32'h0, 0);

    // Backpressure: output holds word@0, skid word@4, requests stop
    do_reset();
    wait_valid();
    repeat (6) @(negedge clk);
    chk("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("bp_pc", bus.instr_pc, 32'h0);
    chk("bp_instr", bus.instr, 32'hE000_0000);
    chk("bp_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    chk("bp_rel_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("bp_rel_pc", bus.instr_pc, 32'h4);
    chk("bp_rel_instr", bus.instr, 32'hE000_0004);
    chk("bp_rel_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("bp_rel_addr", bus.imem_req_addr, 32'h8);
    take(32'h4, 32'hE000_0004, 2'b11, 1'b0, 32'h0, 0);
    take(32'h8, 32'hE000_0008, 2'b11, 1'b0, 32'h0, 0);
    take(32'hC, 32'hE000_000C, 2'b11, 1'b0, 32'h0, 0);

    // Taken branch back to 0x0C (fetch of 0x14 in flight gets dropped), then not taken
    take(32'h10, 32'h1000_FFFE, 2'b01, 1'b1, 32'h0, 0);
    take(32'hC, 32'hE000_000C, 2'b11, 1'b0, 32'h0, 0);
    take(32'h10, 32'h1000_FFFE, 2'b01, 1'b0, 32'h0, 0);
    // jr to 0x100 (low bits cleared), jump self-loop at 0x100, jr to 0x2000
    take(32'h14, 32'hE000_0014, 2'b00, 1'b0, 32'h0000_0103, 0);
    take(32'h100, 32'h0800_0040, 2'b10, 1'b0, 32'h0, 0);
    take(32'h100, 32'h0800_0040, 2'b00, 1'b0, 32'h0000_2003, 0);
    take(32'h2000, 32'hE000_2000, 2'b11, 1'b0, 32'h0, 0);

    // Redirect in the same cycle as the 0x2008 response
    take(32'h2004, 32'hE000_2004, 2'b00, 1'b0, 32'h0000_0043, 1);
    chk("rd_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rd_req_addr", bus.imem_req_addr, 32'h40);
    chk("rd_squash_valid", {31'd0, bus.instr_valid}, 32'd0);
    @(negedge clk);
    chk("rd_wait_valid", {31'd0, bus.instr_valid}, 32'd0);
    @(negedge clk);
    chk("rd_lat_valid", {31'd0, bus.instr_valid}, 32'd1);
    take(32'h40, 32'hE000_0040, 2'b11, 1'b0, 32'h0, 0);
    take(32'h44, 32'hE000_0044, 2'b11, 1'b0, 32'h0, 0);

    // Reset while 0x48 is outstanding, with stale responses around release
    chk("mid_outstanding", {31'd0, bus.imem_req_valid}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    inj_v = 1'b1;
    inj_d = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("mid_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("mid_req_addr", bus.imem_req_addr, 32'h0);
    @(negedge clk);
    inj_v = 1'b0;
    take(32'h0, 32'hE000_0000, 2'b11, 1'b0, 32'h0, 0);
    take(32'h4, 32'hE000_0004, 2'b11, 1'b0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer end of the instruction stream that the instruction decoder consumes.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel. Accepts responses on a valid-only response channel.
- Presents instructions to the decoder stage through a valid/ready handshake, buffered by an output register plus a one-entry skid buffer.
- On acceptance of each instruction, takes the decoder's PC select, branch outcome and register target, computes the next PC, and squashes wrong-path fetches. No branch delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  32  word-aligned fetch address
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  response data valid, one per accepted request, in order, latency ≥1 cycle
- imem_rsp_data  in  32  fetched instruction word
- instr_valid  out  1  instr/instr_pc valid toward the decoder
- instr  out  32  instruction word
- instr_pc  out  32  address of instr
- instr_ready  in  1  decoder stage accepts instr this cycle
- pc_mux_sel  in  2  next-PC select for the instruction being accepted: 00 register (jr/jalr), 01 branch, 10 jump (j/jal), 11 sequential
- branch_taken  in  1  branch condition result; used only when pc_mux_sel=01
- reg_target  in  32  rs value for pc_mux_sel=00

Behaviour:
- Reset: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0. fetch_pc=RESET_PC; outstanding, skid_valid and drop all cleared. First request is asserted the cycle after rst deasserts. rst mid-transaction abandons everything; any later imem_rsp_valid is ignored until a post-reset request has been accepted.
- Accept event: instr_valid & instr_ready. Pc_mux_sel, branch_taken and reg_target are sampled only in the accept cycle.
- Request issue: imem_req_valid=1 when !outstanding && !skid_valid. Address is fetch_pc.
  - On req handshake: outstanding←1; fetch_pc←fetch_pc+4 (mod 2^32, wrap allowed).
  - At most one outstanding request.
- Response arrival (imem_rsp_valid, only meaningful while outstanding): outstanding←0, then:
  - if drop: discard the word, drop←0;
  - else if the output register is empty or an accept occurs this cycle: load it (instr_pc = address of that request);
  - else: load the skid buffer.
- Output refill: on accept with a full skid and no redirect, skid moves to the output register the same edge and skid_valid←0.
- Next-PC on accept, with pc4 = instr_pc+4:
  - 11 → no redirect.
  - 01 & !branch_taken → no redirect.
  - 01 & branch_taken → pc4 + (sign_ext(instr[15:0])<<2).
  - 10 → {pc4[31:28], instr[25:0], 2'b00}.
  - 00 → {reg_target[31:2], 2'b00} (low bits forced to 0).
- Redirect on accept:
  - fetch_pc←target; skid_valid←0; instr_valid←0 next cycle.
  - If outstanding and no response in the same cycle, drop←1.
  - A response arriving in the redirect cycle is discarded.
  - A request handshake in the redirect cycle (old address) sets outstanding=1 and drop=1; fetch_pc takes the target, not +4.
  - Target fetch is issued as soon as outstanding clears.
- Redirect latency: with a 1-cycle memory and the bus idle, the target request is asserted the cycle after accept, and instr_valid for the target appears 2 cycles after that request handshake.
- Steady state: sustains one instruction per 2 cycles with 1-cycle memory latency, because of the single outstanding request.
- instr/instr_pc must hold stable while instr_valid & !instr_ready.

Decomposition:
- Shared package:
  - PC_SEL_REG=2'b00, PC_SEL_BRANCH=2'b01, PC_SEL_JUMP=2'b10, PC_SEL_SEQ=2'b11 (identical to the decoder's PC select encoding);
  - WORD=32, PC_INCR=4.
- One combinational sub-module, next_pc_calc: inputs instr, instr_pc, pc_mux_sel, branch_taken, reg_target; outputs redirect and target.

Test Plan:
- Reset release, RESET_PC=0, memory returns addr-tagged words, instr_ready=1 → instr_pc sequence 0,4,8,C; the first request is issued the cycle after rst drops.
- Backpressure: hold instr_ready=0 for 6 cycles → output holds word@0, skid holds word@4, no third request. Release → word@4 presented the next cycle, then requests resume at 8.
- Taken branch: instr at 0x10 = 0x1000FFFE (beq, imm=-2), pc_mux_sel=01, branch_taken=1 → next accepted instr_pc=0x0C; the in-flight fetch of 0x14 is dropped.
- Not-taken branch: same instruction, branch_taken=0 → next instr_pc=0x14.
- Jump and jr:
  - instr=0x08000040 at 0x100 → next fetch 0x100.
  - pc_mux_sel=00, reg_target=0x2003 → next fetch 0x2000.
- Redirect coinciding with an imem response and with a request handshake → both wrong-path words discarded, exactly one target word delivered. Rst asserted mid-WAIT → next instr_pc=RESET_PC, stale response ignored.
